countdown_timer: RTL and testbench

//  Loadable down-counter: decrements from a value accepted over a valid/ready load port.

---
 rtl/countdown_timer_pkg.sv | 12 +
 rtl/countdown_timer_if.sv | 29 ++
 rtl/countdown_timer.sv | 97 +++++++++
 tb/tb_countdown_timer.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/countdown_timer_pkg.sv
// Shared definitions for the countdown timer: FSM state encoding and default counter width.
package countdown_timer_pkg;

  localparam int unsigned CD_WIDTH_DEFAULT = 4;

  typedef enum logic [1:0] {
    CD_IDLE = 2'd0,
    CD_RUN  = 2'd1,
    CD_DONE = 2'd2
  } cd_state_e;

endpackage

// File: rtl/countdown_timer_if.sv
// Load / control / expire signal bundle for countdown_timer.
// The master drives loads and consumes expiry; the slave is the timer.
interface countdown_timer_if
  import countdown_timer_pkg::*;
#(
  parameter int unsigned WIDTH = CD_WIDTH_DEFAULT
) ();

  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] load_value;
  logic             pause;
  logic             cancel;
  logic [WIDTH-1:0] count_out;
  logic             busy;
  logic             expire_valid;
  logic             expire_ready;

  modport master (
    output load_valid, load_value, pause, cancel, expire_ready,
    input  load_ready, count_out, busy, expire_valid
  );

  modport slave (
    input  load_valid, load_value, pause, cancel, expire_ready,
    output load_ready, count_out, busy, expire_valid
  );

endinterface

// File: rtl/countdown_timer.sv
// Loadable down-counter with valid/ready load and expire ports (watchdog / N-cycle delay).
// Define COUNTDOWN_AUTORELOAD_EN to restart from the last loaded value after each expiry.
module countdown_timer
  import countdown_timer_pkg::*;
#(
  parameter int unsigned WIDTH = CD_WIDTH_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  countdown_timer_if.slave   tmr
);

  cd_state_e        state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
`ifdef COUNTDOWN_AUTORELOAD_EN
  logic [WIDTH-1:0] reload_q, reload_d;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= CD_IDLE;
      count_q  <= '0;
`ifdef COUNTDOWN_AUTORELOAD_EN
      reload_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
`ifdef COUNTDOWN_AUTORELOAD_EN
      reload_q <= reload_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
`ifdef COUNTDOWN_AUTORELOAD_EN
    reload_d = reload_q;
`endif
    case (state_q)
      CD_IDLE: begin
        // cancel is ignored here, so a same-cycle load still goes through
        if (tmr.load_valid) begin
`ifdef COUNTDOWN_AUTORELOAD_EN
          reload_d = tmr.load_value;
`endif
          count_d = tmr.load_value;
          state_d = (tmr.load_value != '0) ? CD_RUN : CD_DONE;
        end
      end
      CD_RUN: begin
        if (tmr.cancel) begin
          count_d = '0;
          state_d = CD_IDLE;
        end else if (!tmr.pause) begin
          // <= 1 rather than == 1 so a corrupted zero can never wrap to all-ones
          if (count_q <= WIDTH'(1)) begin
            count_d = '0;
            state_d = CD_DONE;
          end else begin
            count_d = count_q - WIDTH'(1);
          end
        end
      end
      CD_DONE: begin
        count_d = '0;
        if (tmr.cancel) begin
          state_d = CD_IDLE;
        end else if (tmr.expire_ready) begin
`ifdef COUNTDOWN_AUTORELOAD_EN
          if (reload_q != '0) begin
            count_d = reload_q;
            state_d = CD_RUN;
          end else begin
            state_d = CD_IDLE;
          end
`else
          state_d = CD_IDLE;
`endif
        end
      end
      default: begin
        count_d = '0;
        state_d = CD_IDLE;
      end
    endcase
  end

  always_comb begin
    tmr.load_ready   = (state_q == CD_IDLE);
    tmr.busy         = (state_q == CD_RUN);
    tmr.expire_valid = (state_q == CD_DONE);
    tmr.count_out    = count_q;
  end

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer: directed scenarios plus randomized traffic
// compared every cycle against a behavioural model of remaining cycles and pending expiry.
module tb_countdown_timer;

`ifdef COUNTDOWN_AUTORELOAD_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   checks   = 0;
  int   failures = 0;
  bit   cmp_en   = 1'b0;

  countdown_timer_if #(.WIDTH(4)) tif ();

  countdown_timer #(.WIDTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .tmr   (tif.slave)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    int unsigned cnt;
    bit          busy;
    bit          exp;
    int unsigned rel;
  } mstate_t;

  mstate_t m;

  function automatic mstate_t model_next(mstate_t s, bit lv, int unsigned val, bit pz, bit cn,
                                         bit er);
    mstate_t n = s;
    if (!s.busy && !s.exp) begin
      if (lv) begin
        n.rel = val;
        n.cnt = val;
        if (val == 0) n.exp = 1'b1;
        else          n.busy = 1'b1;
      end
    end else if (cn) begin
      n.busy = 1'b0;
      n.exp  = 1'b0;
      n.cnt  = 0;
    end else if (s.busy) begin
      if (!pz) begin
        n.cnt = s.cnt - 1;
        if (n.cnt == 0) begin
          n.busy = 1'b0;
          n.exp  = 1'b1;
        end
      end
    end else if (er) begin
      n.exp = 1'b0;
      if (AUTO && s.rel != 0) begin
        n.busy = 1'b1;
        n.cnt  = s.rel;
      end
    end
    return n;
  endfunction

  task automatic check(input string name, input int unsigned act, input int unsigned expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  // Reference model, advanced on the same edges as the DUT
  initial begin
    m = '0;
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) m = '0;
      else m = model_next(m, tif.load_valid, 32'(tif.load_value), tif.pause, tif.cancel,
                          tif.expire_ready);
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        check("cyc_count", 32'(tif.count_out), m.cnt);
        check("cyc_busy", 32'(tif.busy), 32'(m.busy));
        check("cyc_expire", 32'(tif.expire_valid), 32'(m.exp));
        check("cyc_ready", 32'(tif.load_ready), 32'(!m.busy && !m.exp));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic load(input int unsigned v);
    tif.load_valid = 1'b1;
    tif.load_value = 4'(v);
    step();
    tif.load_valid = 1'b0;
  endtask

  int n_cyc;
  int n_exp;

  initial begin
    tif.load_valid   = 1'b0;
    tif.load_value   = '0;
    tif.pause        = 1'b0;
    tif.cancel       = 1'b0;
    tif.expire_ready = 1'b1;
    step();
    check("rst_count", 32'(tif.count_out), 0);
    check("rst_ready", 32'(tif.load_ready), 1);
    check("rst_expire", 32'(tif.expire_valid), 0);
    reset = 1'b1;
    step();
    cmp_en = 1'b1;

    // 1: load 3 counts 3,2,1,0 then one expiry and back to idle
    load(3);
    check("t1_count3", 32'(tif.count_out), 3);
    check("t1_model3", m.cnt, 3);
    check("t1_busy", 32'(tif.busy), 1);
    step();
    check("t1_count2", 32'(tif.count_out), 2);
    step();
    check("t1_count1", 32'(tif.count_out), 1);
    step();
    check("t1_count0", 32'(tif.count_out), 0);
    check("t1_expire", 32'(tif.expire_valid), 1);
    check("t1_model_exp", 32'(m.exp), 1);
    step();
    check("t1_expire_drop", 32'(tif.expire_valid), 0);
    check("t1_idle_ready", 32'(tif.load_ready), 1);

    // 2: load 5 with two paused cycles -> 7 cycles to expiry
    load(5);
    n_cyc = 0;
    for (int i = 1; i <= 40; i++) begin
      tif.pause = (i == 3 || i == 4);
      step();
      if (tif.expire_valid) begin
        n_cyc = i;
        break;
      end
    end
    tif.pause = 1'b0;
    check("t2_latency", 32'(n_cyc), 7);
    step();

    // 3: zero load expires next cycle and holds while not consumed
    tif.expire_ready = 1'b0;
    load(0);
    check("t3_expire", 32'(tif.expire_valid), 1);
    for (int i = 0; i < 4; i++) begin
      step();
      check("t3_hold", 32'(tif.expire_valid), 1);
    end
    tif.expire_ready = 1'b1;
    step();
    check("t3_consumed", 32'(tif.expire_valid), 0);
    check("t3_ready", 32'(tif.load_ready), 1);

    // 4: cancel at count 4, then cancel in idle alongside a load
    load(9);
    for (int i = 0; i < 5; i++) step();
    check("t4_count4", 32'(tif.count_out), 4);
    tif.cancel = 1'b1;
    step();
    check("t4_count0", 32'(tif.count_out), 0);
    check("t4_busy", 32'(tif.busy), 0);
    check("t4_expire", 32'(tif.expire_valid), 0);
    check("t4_ready", 32'(tif.load_ready), 1);
    load(2);
    check("t4_idle_cancel_load", 32'(tif.count_out), 2);
    check("t4_idle_cancel_busy", 32'(tif.busy), 1);
    step();
    check("t4_cancel_run", 32'(tif.busy), 0);
    tif.cancel = 1'b0;

    // 5: asynchronous reset mid-run
    load(9);
    for (int i = 0; i < 3; i++) step();
    check("t5_count6", 32'(tif.count_out), 6);
    #1 reset = 1'b0;
    #1;
    check("t5_count", 32'(tif.count_out), 0);
    check("t5_busy", 32'(tif.busy), 0);
    check("t5_expire", 32'(tif.expire_valid), 0);
    check("t5_ready", 32'(tif.load_ready), 1);
    step();
    reset = 1'b1;
    step();

    // 6: periodic expiry only with autoreload
    load(2);
    n_exp = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (tif.expire_valid) n_exp++;
    end
    check("t6_expiries", 32'(n_exp), AUTO ? 4 : 1);
    tif.cancel = 1'b1;
    step();
    tif.cancel = 1'b0;
    check("t6_cancel_idle", 32'(tif.load_ready), 1);

    // Randomized traffic, checked every cycle by the compare process
    for (int i = 0; i < 3000; i++) begin
      tif.load_valid   = ($urandom_range(0, 3) == 0);
      tif.load_value   = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 3))
                                                     : 4'($urandom_range(0, 15));
      tif.pause        = ($urandom_range(0, 3) == 0);
      tif.cancel       = ($urandom_range(0, 31) == 0);
      tif.expire_ready = ($urandom_range(0, 2) != 0);
      step();
    end

    tif.load_valid = 1'b0;
    tif.cancel     = 1'b0;
    step();
    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
